divide_restoring: RTL and testbench
===================================

// Module: divide_restoring
// PURPOSE
//   Sequential unsigned restoring divider; the inverse of the 4-bit shift-add multiplier.
//   Accepts an 8-bit dividend (e.g. a multiplier product P) and a 4-bit divisor on start.
//   Produces quotient Q and remainder R after N_W iteration cycles (one quotient bit per clock),
//   then flags completion on stop. Sits beside the multiplier in the arithmetic datapath.
// PARAMETERS
//   N_W  8  dividend and quotient width
//   D_W  4  divisor and remainder width (D_W <= N_W)
// PORTS
//   clk    in   1     single clock; all state changes on rising edge
//   rst    in   1     reset; synchronous, active-high
//   start  in   1     sampled in IDLE/DONE: latch N, D and begin a division
//   N      in   N_W   unsigned dividend
//   D      in   D_W   unsigned divisor
//   Q      out  N_W   quotient; valid while stop=1
//   R      out  D_W   remainder; valid while stop=1
//   busy   out  1     high while iterating
//   stop   out  1     high (level) from completion until next accepted start or rst
//   dz     out  1     divide-by-zero flag; valid while stop=1
// BEHAVIOUR
//   Reset: rst=1 at an edge -> state IDLE; Q=0, R=0, busy=0, stop=0, dz=0, count=0. Overrides start.
//   Mid-operation reset aborts the division; no partial result is exposed.
//   FSM states: IDLE, RUN, DONE.
//   IDLE/DONE with start=1 at edge E0, D!=0:
//     A(D_W+1 bits)=0, Qr=N, Dr=D, count=N_W; stop=0, dz=0, busy=1; go RUN.
//   IDLE/DONE with start=1, D==0: go DONE directly at E0.
//     Q={N_W{1}}, R=0, dz=1, stop=1, busy=0.
//   RUN, each edge:
//     {A,Qr} shifted left 1.
//     T = A_sh - {1'b0,Dr} in D_W+2 bits.
//     T non-negative -> A=T[D_W:0] and Qr[0]=1; otherwise A=A_sh and Qr[0]=0.
//     count-1.
//   RUN exit: the edge where count goes 1->0 (edge E_N_W) moves to DONE.
//     At that edge Q=Qr (final), R=A[D_W-1:0], stop=1, busy=0.
//   Latency: stop rises N_W edges after the start edge (8 for defaults).
//   start during RUN is ignored; latched operands are unaffected by N/D changes after E0.
//   DONE holds Q/R/dz/stop stable indefinitely. A start there restarts the divider, with stop=0
//     from that edge (back-to-back operation, no IDLE visit required).
//   Invariant at DONE with dz=0: N == Q*D + R and R < D. Since R < D <= 2^D_W-1, R fits D_W.
//   Q may need all N_W bits (e.g. N/1 = N); no overflow condition exists.
// STRUCTURE
//   Shared include div_defs.vh:
//     state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//     counter width macro CNT_W = $clog2(N_W+1)
//   Sub-module div_step (combinational, parameter D_W): in A_sh, Dr; out A_next, q_bit.
//     Implements the trial subtract/restore.
//   Top holds the FSM, counter and the A/Qr/Dr registers.
// TESTING
//   1 rst held 2 cycles then released -> Q=0, R=0, stop=0, busy=0, dz=0.
//   2 N=200, D=7, start 1 cycle -> busy 8 cycles; stop rises 8 edges after start; Q=28, R=4, dz=0.
//   3 N=143, D=13 (multiplier product 13*11) -> Q=11, R=0.
//   4 N=5, D=9 -> Q=0, R=5.
//   4 N=255, D=1 -> Q=255, R=0.
//   5 N=100, D=0 -> stop=1 one edge after start, Q=255, R=0, dz=1, busy never 1.
//   6 Mid-run and back-to-back control:
//     start N=200, D=7; rst asserted 3 edges later -> IDLE, all outputs 0.
//     Then N=255, D=15 started in DONE immediately after a prior result -> Q=17, R=0.
//     start pulsed during RUN with other operands -> ignored; result unchanged.

Source files
------------

// File: rtl/divide_restoring_pkg.sv
// Shared constants for the restoring divider: FSM encodings and counter sizing.
package divide_restoring_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter must hold the value n_w itself, hence n_w+1.
  function automatic int cnt_width(input int n_w);
    return $clog2(n_w + 1);
  endfunction

endpackage

// File: rtl/divide_restoring_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when it does not go negative.
module div_step #(
  parameter int D_W = 4
) (
  input  logic [D_W+1:0] a_sh,
  input  logic [D_W-1:0] dr,
  output logic [D_W:0]   a_next,
  output logic           q_bit
);

  logic [D_W+1:0] w_t;

  assign w_t    = a_sh - {2'b00, dr};
  assign q_bit  = ~w_t[D_W+1];
  assign a_next = q_bit ? w_t[D_W:0] : a_sh[D_W:0];

endmodule

// File: rtl/divide_restoring.sv
// Sequential unsigned restoring divider producing one quotient bit per clock;
// results are held on Q/R/dz while stop is high.
module divide_restoring
  import divide_restoring_pkg::*;
#(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] N,
  input  logic [D_W-1:0] D,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           busy,
  output logic           stop,
  output logic           dz
);

  localparam int CNT_W = cnt_width(N_W);

  logic [1:0]       r_state;
  logic [D_W:0]     r_a;
  logic [N_W-1:0]   r_qr;
  logic [D_W-1:0]   r_dr;
  logic [CNT_W-1:0] r_count;
  logic [N_W-1:0]   r_q;
  logic [D_W-1:0]   r_r;
  logic             r_busy;
  logic             r_stop;
  logic             r_dz;

  logic [D_W+1:0]   w_a_sh;
  logic [D_W:0]     w_a_next;
  logic             w_q_bit;

  // Full {A,Qr} left shift keeps the bit leaving A, so the trial subtract sees it.
  assign w_a_sh = {r_a, r_qr[N_W-1]};

  div_step #(
    .D_W(D_W)
  ) u_step (
    .a_sh  (w_a_sh),
    .dr    (r_dr),
    .a_next(w_a_next),
    .q_bit (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_qr    <= '0;
      r_dr    <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_stop  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (D != '0) begin
              r_a     <= '0;
              r_qr    <= N;
              r_dr    <= D;
              r_count <= CNT_W'(N_W);
              r_stop  <= 1'b0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_q     <= '1;
              r_r     <= '0;
              r_dz    <= 1'b1;
              r_stop  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_a     <= w_a_next;
          r_qr    <= {r_qr[N_W-2:0], w_q_bit};
          r_count <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) begin
            r_q     <= {r_qr[N_W-2:0], w_q_bit};
            r_r     <= w_a_next[D_W-1:0];
            r_stop  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign busy = r_busy;
  assign stop = r_stop;
  assign dz   = r_dz;

endmodule

// File: tb/tb_divide_restoring.sv
// Self-checking bench for divide_restoring: vector table plus scoreboard, with
// hand-written sequences for mid-run reset, back-to-back starts and ignored starts.
module tb_divide_restoring;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] N;
  logic [3:0] D;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       stop;
  logic       dz;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[9];

  divide_restoring #(
    .N_W(8),
    .D_W(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .N    (N),
    .D    (D),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .stop (stop),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Starts a division, optionally pulses start with other operands after poke_at
  // edges, then waits for stop and checks timing and the scoreboard entry.
  task automatic run_div(input logic [7:0] n, input logic [3:0] d, input logic [7:0] eq,
                         input logic [3:0] er, input logic edz, input int poke_at);
    int   edges;
    int   busy_cnt;
    vec_t e;
    vec_t got;
    logic [7:0] q_hold;
    @(negedge clk);
    N = n;
    D = d;
    start = 1'b1;
    e.n = n; e.d = d; e.q = eq; e.r = er; e.dz = edz;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    check("stop_after_start", {31'd0, stop}, {31'd0, edz});
    while (!stop && edges < 40) begin
      if (busy) busy_cnt++;
      if (edges == poke_at) begin
        N = ~n;
        D = d + 4'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    if (!stop) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got stop=0 expected stop=1 within 40 edges");
    end
    check("latency", edges, edz ? 0 : 8);
    check("busy_cycles", busy_cnt, edz ? 0 : 8);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb_q.pop_front();
      check("quotient", Q, got.q);
      check("remainder", R, got.r);
      check("dz", dz, got.dz);
      $display("[TB] N=%0d D=%0d -> Q=%0d R=%0d dz=%0d busy_cycles=%0d latency=%0d",
               got.n, got.d, Q, R, dz, busy_cnt, edges);
    end
    q_hold = Q;
    @(negedge clk);
    check("done_hold_stop", stop, 1);
    check("done_hold_q", Q, q_hold);
  endtask

  initial begin
    vecs[0] = '{n: 8'd200, d: 4'd7,  q: 8'd28,  r: 4'd4,  dz: 1'b0};
    vecs[1] = '{n: 8'd143, d: 4'd13, q: 8'd11,  r: 4'd0,  dz: 1'b0};
    vecs[2] = '{n: 8'd5,   d: 4'd9,  q: 8'd0,   r: 4'd5,  dz: 1'b0};
    vecs[3] = '{n: 8'd255, d: 4'd1,  q: 8'd255, r: 4'd0,  dz: 1'b0};
    vecs[4] = '{n: 8'd100, d: 4'd0,  q: 8'd255, r: 4'd0,  dz: 1'b1};
    vecs[5] = '{n: 8'd255, d: 4'd15, q: 8'd17,  r: 4'd0,  dz: 1'b0};
    vecs[6] = '{n: 8'd254, d: 4'd15, q: 8'd16,  r: 4'd14, dz: 1'b0};
    vecs[7] = '{n: 8'd0,   d: 4'd5,  q: 8'd0,   r: 4'd0,  dz: 1'b0};
    vecs[8] = '{n: 8'd14,  d: 4'd15, q: 8'd0,   r: 4'd14, dz: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    N = '0;
    D = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_q", Q, 0);
    check("reset_r", R, 0);
    check("reset_stop", stop, 0);
    check("reset_busy", busy, 0);
    check("reset_dz", dz, 0);

    foreach (vecs[i])
      run_div(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dz, -1);

    for (int k = 0; k < 4; k++) begin
      logic [7:0] rn;
      logic [3:0] rd;
      rn = 8'($urandom_range(0, 255));
      rd = 4'($urandom_range(1, 15));
      run_div(rn, rd, rn / {4'd0, rd}, 4'(rn % {4'd0, rd}), 1'b0, -1);
    end

    // Mid-run reset: start 200/7, assert rst on the third edge after the start edge.
    @(negedge clk);
    N = 8'd200;
    D = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_q", Q, 0);
    check("midrun_rst_r", R, 0);
    check("midrun_rst_stop", stop, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_dz", dz, 0);
    $display("[TB] mid-run reset -> Q=%0d R=%0d busy=%0d stop=%0d dz=%0d", Q, R, busy, stop, dz);

    // Back-to-back: a new start issued straight from DONE.
    run_div(8'd200, 8'd7, 8'd28, 4'd4, 1'b0, -1);
    run_div(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, -1);

    // start pulsed mid-run with different operands must be ignored.
    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 3);
    run_div(8'd143, 4'd13, 8'd11, 4'd0, 1'b0, 6);

    // dz result followed directly by a normal division from DONE.
    run_div(8'd100, 4'd0, 8'd255, 4'd0, 1'b1, -1);
    run_div(8'd143, 4'd13, 8'd11, 4'd0, 1'b0, -1);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
